// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM encoding and
// iteration-count helpers used by the top and the mul/div core.
package ula_pkg;

  localparam logic [3:0] ULA_ADD   = 4'h0;
  localparam logic [3:0] ULA_SUB   = 4'h1;
  localparam logic [3:0] ULA_AND   = 4'h2;
  localparam logic [3:0] ULA_OR    = 4'h3;
  localparam logic [3:0] ULA_XOR   = 4'h4;
  localparam logic [3:0] ULA_SLT   = 4'h5;
  localparam logic [3:0] ULA_SLL   = 4'h6;
  localparam logic [3:0] ULA_SRL   = 4'h7;
  localparam logic [3:0] ULA_SRA   = 4'h8;
  localparam logic [3:0] ULA_SLTU  = 4'h9;
  localparam logic [3:0] ULA_MUL   = 4'hA;
  localparam logic [3:0] ULA_MULHU = 4'hB;
  localparam logic [3:0] ULA_DIV   = 4'hC;
  localparam logic [3:0] ULA_DIVU  = 4'hD;
  localparam logic [3:0] ULA_REM   = 4'hE;
  localparam logic [3:0] ULA_REMU  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } ula_state_e;

  function automatic int ula_iters(input int width, input int unroll);
    return width / unroll;
  endfunction

  function automatic int ula_cnt_w(input int iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

endpackage

// File: rtl/ula_muldiv_core.sv
// Iterative multiply / restoring divide datapath. hi/lo form one shared
// double-width register: product {hi,lo}, or remainder=hi / quotient=lo.
module ula_muldiv_core
  import ula_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             calc,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = ula_iters(WIDTH, UNROLL);
  localparam int CW = ula_cnt_w(N);
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  logic [WIDTH-1:0] b_q;
  logic             div_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [2*WIDTH:0] p;
  logic [WIDTH:0]   t;

  // One cycle retires UNROLL bits: shift-add for multiply (multiplier in lo,
  // consumed LSB first), restore-compare for divide (dividend shifts out of lo).
  always_comb begin
    hi_n = hi;
    lo_n = lo;
    p    = '0;
    t    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (div_q) begin
        t    = {hi_n, lo_n[WIDTH-1]};
        lo_n = {lo_n[WIDTH-2:0], 1'b0};
        if (t >= {1'b0, b_q}) begin
          t       = t - {1'b0, b_q};
          lo_n[0] = 1'b1;
        end
        hi_n = t[WIDTH-1:0];
      end else begin
        p = {1'b0, hi_n, lo_n};
        if (p[0]) p[2*WIDTH:WIDTH] = p[2*WIDTH:WIDTH] + {1'b0, b_q};
        p    = p >> 1;
        hi_n = p[2*WIDTH-1:WIDTH];
        lo_n = p[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q   <= '0;
      div_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else if (start) begin
      b_q   <= opb;
      div_q <= is_div;
      hi    <= '0;
      lo    <= opa;
      cnt   <= CNT_INIT;
    end else if (calc) begin
      hi <= hi_n;
      lo <= lo_n;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign done = calc && (cnt == '0);

endmodule

// File: rtl/ula_seq.sv
// Handshaked integer ALU for the EX stage: single-cycle ALU ops plus
// iterative RV64M multiply/divide, one operation in flight at a time.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output ula_state_e       state_dbg
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_SIGNED = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; flush wins over in_valid, and a consuming edge never accepts.
  ula_state_e state, state_n;
  logic accept, is_iter, is_div, div_signed, b_zero, div_ovf, bypass, start_iter;
  logic s1, s2, fix_hi_q, fix_neg_q, core_done;
  logic [WIDTH-1:0] mag1, mag2, alu_res, special_res, core_hi, core_lo, fix_sel, fix_res;
  logic [SHAMT_W-1:0] shamt;

  assign accept     = in_valid && in_ready && !flush;
  assign is_iter    = op[3] && (op[2] || op[1]);
  assign is_div     = op[3] && op[2];
  assign div_signed = is_div && !op[0];
  assign b_zero     = (operand2 == '0);
  assign div_ovf    = div_signed && (operand1 == MIN_SIGNED) && (operand2 == '1);
  assign bypass     = is_div && (b_zero || div_ovf);
  assign start_iter = accept && is_iter && !bypass;
  assign s1         = div_signed && operand1[WIDTH-1];
  assign s2         = div_signed && operand2[WIDTH-1];
  assign mag1       = s1 ? -operand1 : operand1;
  assign mag2       = s2 ? -operand2 : operand2;
  assign shamt      = operand2[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      ULA_ADD:  alu_res = operand1 + operand2;
      ULA_SUB:  alu_res = operand1 - operand2;
      ULA_AND:  alu_res = operand1 & operand2;
      ULA_OR:   alu_res = operand1 | operand2;
      ULA_XOR:  alu_res = operand1 ^ operand2;
      ULA_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(operand1) < $signed(operand2)};
      ULA_SLL:  alu_res = operand1 << shamt;
      ULA_SRL:  alu_res = operand1 >> shamt;
      ULA_SRA:  alu_res = $signed(operand1) >>> shamt;
      ULA_SLTU: alu_res = {{(WIDTH-1){1'b0}}, operand1 < operand2};
      default:  alu_res = '0;
    endcase
  end

  // Divide-by-zero and signed overflow follow the RISC-V defined results.
  always_comb begin
    special_res = '0;
    if (b_zero) special_res = op[1] ? operand1 : '1;
    else        special_res = op[1] ? '0 : MIN_SIGNED;
  end

  ula_muldiv_core #(.WIDTH(WIDTH), .UNROLL(UNROLL)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_iter),
    .calc   (state == ST_CALC),
    .is_div (is_div),
    .opa    (is_div ? mag1 : operand1),
    .opb    (is_div ? mag2 : operand2),
    .done   (core_done),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  // FIX picks hi (MULHU / remainder) or lo (MUL / quotient), then negates if needed.
  assign fix_sel = fix_hi_q ? core_hi : core_lo;
  assign fix_res = fix_neg_q ? -fix_sel : fix_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) state_n = ST_IDLE;
    else begin
      case (state)
        ST_IDLE: if (accept) state_n = start_iter ? ST_CALC : ST_DONE;
        ST_CALC: if (core_done) state_n = ST_FIX;
        ST_FIX:  state_n = ST_DONE;
        ST_DONE: if (out_ready) state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      fix_hi_q  <= 1'b0;
      fix_neg_q <= 1'b0;
    end else begin
      if (accept && !is_iter)          result <= alu_res;
      else if (accept && bypass)       result <= special_res;
      else if (state == ST_FIX && !flush) result <= fix_res;
      if (start_iter) begin
        fix_hi_q  <= is_div ? op[1] : op[0];
        fix_neg_q <= op[1] ? s1 : (s1 ^ s2);
      end
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: two instances (UNROLL=1 and UNROLL=4) share stimulus;
// results are scored against a behavioural model of the ALU semantics.
module tb_ula_seq;
  import ula_pkg::*;

  localparam int W  = 64;
  localparam int SH = $clog2(W);
  localparam int N1 = W / 1;
  localparam int N4 = W / 4;
  localparam logic [W-1:0] MIN_S = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] op = '0;
  logic [W-1:0] operand1 = '0, operand2 = '0;
  logic in_ready, out_valid, zero, busy;
  logic in_ready4, out_valid4, zero4, busy4;
  logic [W-1:0] result, result4;
  ula_state_e state_dbg, state_dbg4;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  ula_seq #(.WIDTH(W), .UNROLL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand1(operand1), .operand2(operand2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy), .state_dbg(state_dbg)
  );

  ula_seq #(.WIDTH(W), .UNROLL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .op(op), .operand1(operand1), .operand2(operand2), .out_valid(out_valid4),
    .out_ready(out_ready), .result(result4), .zero(zero4), .busy(busy4), .state_dbg(state_dbg4)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_model(input logic [3:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    logic ovf;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    ovf  = (a == MIN_S) && (b == '1);
    case (o)
      ULA_ADD:   return a + b;
      ULA_SUB:   return a - b;
      ULA_AND:   return a & b;
      ULA_OR:    return a | b;
      ULA_XOR:   return a ^ b;
      ULA_SLT:   return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      ULA_SLL:   return a << b[SH-1:0];
      ULA_SRL:   return a >> b[SH-1:0];
      ULA_SRA:   return W'($signed(a) >>> b[SH-1:0]);
      ULA_SLTU:  return (a < b) ? W'(1) : W'(0);
      ULA_MUL:   return prod[W-1:0];
      ULA_MULHU: return prod[2*W-1:W];
      ULA_DIV:   return (b == '0) ? '1 : ovf ? MIN_S : W'($signed(a) / $signed(b));
      ULA_DIVU:  return (b == '0) ? '1 : a / b;
      ULA_REM:   return (b == '0) ? a : ovf ? '0 : W'($signed(a) % $signed(b));
      default:   return (b == '0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int n);
    if (o < ULA_MUL) return 1;
    if (o >= ULA_DIV && b == '0) return 1;
    if ((o == ULA_DIV || o == ULA_REM) && a == MIN_S && b == '1) return 1;
    return n + 2;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return MIN_S;
      3:       return W'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // hold < 0: out_ready high throughout; otherwise hold DONE for 'hold' cycles.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_v, input int hold);
    int lat1, lat4, cyc, e1, e4;
    logic [W-1:0] r1, r4, exp_r;
    logic z1, z4;
    e1 = ref_lat(o, a, b, N1);
    e4 = ref_lat(o, a, b, N4);
    exp_q.push_back(exp_v);
    check($sformatf("%s.in_ready", tag), W'(in_ready & in_ready4), W'(1));
    op = o; operand1 = a; operand2 = b; in_valid = 1'b1; out_ready = (hold < 0);
    lat1 = 0; lat4 = 0; cyc = 0; r1 = '0; r4 = '0; z1 = 1'b0; z4 = 1'b0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 4'($urandom); operand1 = {$urandom, $urandom}; operand2 = {$urandom, $urandom};
      cyc++;
      if (out_valid && lat1 == 0) begin lat1 = cyc; r1 = result; z1 = zero; end
      if (out_valid4 && lat4 == 0) begin lat4 = cyc; r4 = result4; z4 = zero4; end
    end while ((lat1 == 0 || lat4 == 0) && cyc < 200);
    exp_r = exp_q.pop_front();
    check($sformatf("%s.res1", tag), r1, exp_r);
    check($sformatf("%s.res4", tag), r4, exp_r);
    check($sformatf("%s.zero1", tag), W'(z1), W'(exp_r == '0));
    check($sformatf("%s.zero4", tag), W'(z4), W'(exp_r == '0));
    check($sformatf("%s.lat1", tag), W'(lat1), W'(e1));
    check($sformatf("%s.lat4", tag), W'(lat4), W'(e4));
    if (hold >= 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check($sformatf("%s.hold_res", tag), result, exp_r);
        check($sformatf("%s.hold_vld", tag), W'(out_valid & out_valid4 & busy), W'(1));
        check($sformatf("%s.hold_rdy", tag), W'(in_ready | in_ready4), W'(0));
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check($sformatf("%s.drained", tag), W'(out_valid | out_valid4), W'(0));
    check($sformatf("%s.ready_back", tag), W'(in_ready & in_ready4), W'(1));
    out_ready = 1'b0;
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid || out_valid4) seen++;
    end
    check(tag, W'(seen), W'(0));
  endtask

  initial begin
    logic [3:0] o;
    logic [W-1:0] a, b;

    repeat (3) @(posedge clk);
    check("rst.out_valid", W'(out_valid | out_valid4), W'(0));
    check("rst.busy", W'(busy | busy4), W'(0));
    check("rst.result", result | result4, '0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.in_ready", W'(in_ready & in_ready4), W'(1));
    check("rst.state", W'(state_dbg), W'(ST_IDLE));

    run_op("add", ULA_ADD, 64'd5, 64'd7, 64'd12, -1);
    run_op("sub", ULA_SUB, 64'd9, 64'd9, 64'd0, 0);
    run_op("slt", ULA_SLT, '1, 64'd1, 64'd1, -1);
    run_op("sltu", ULA_SLTU, '1, 64'd1, 64'd0, 1);
    run_op("sra", ULA_SRA, MIN_S, 64'd4, 64'hF800_0000_0000_0000, -1);
    run_op("mul", ULA_MUL, 64'd3, -64'sd4, 64'hFFFF_FFFF_FFFF_FFF4, -1);
    run_op("mulhu", ULA_MULHU, '1, 64'd2, 64'd1, 0);
    run_op("div", ULA_DIV, 64'd7, -64'sd2, -64'sd3, -1);
    run_op("rem", ULA_REM, 64'd7, -64'sd2, 64'd1, -1);
    run_op("divu", ULA_DIVU, 64'd100, 64'd7, 64'd14, -1);
    run_op("div0", ULA_DIV, 64'd1234, 64'd0, '1, -1);
    run_op("rem0", ULA_REM, 64'd5, 64'd0, 64'd5, -1);
    run_op("divovf", ULA_DIV, MIN_S, '1, MIN_S, -1);
    run_op("hold10", ULA_REMU, 64'd1000, 64'd7, 64'd6, 10);

    // Reset in the middle of CALC loses the op.
    op = ULA_MUL; operand1 = 64'd11; operand2 = 64'd13; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid.state", W'(state_dbg), W'(ST_CALC));
    rst_n = 1'b0;
    #2;
    check("arst.out_valid", W'(out_valid | out_valid4), W'(0));
    check("arst.busy", W'(busy | busy4), W'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst.in_ready", W'(in_ready & in_ready4), W'(1));
    watch_quiet("arst.no_result", 80);

    // Flush in the middle of CALC discards the op.
    op = ULA_DIVU; operand1 = 64'd1000; operand2 = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush.idle", W'(busy | busy4), W'(0));
    check("flush.in_ready", W'(in_ready & in_ready4), W'(1));
    watch_quiet("flush.no_result", 80);

    // Flush beats in_valid: nothing is accepted.
    op = ULA_ADD; operand1 = 64'd1; operand2 = 64'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    check("flush_acc.busy", W'(busy | busy4), W'(0));
    watch_quiet("flush_acc.no_result", 5);
    run_op("after_flush", ULA_XOR, 64'hF0F0, 64'h0FF0, 64'hFF00, -1);

    for (int i = 0; i < 50; i++) begin
      o = 4'($urandom);
      a = rnd_val();
      b = rnd_val();
      run_op($sformatf("rnd%0d_op%0h", i, o), o, a, b, ref_model(o, a, b),
             int'($urandom_range(0, 3)) - 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
